// File: rtl/weight_streamer_if.sv
// weight_streamer_if
//   Valid/ready element stream from weight_streamer to an operand register.
//   Parameters:
//     WIDTH     - bits per element
//   Signals:
//     out_valid - sender holds a valid element on out_data
//     out_ready - receiver accepts out_data on this edge
//     out_data  - current element, zero while out_valid is low
//     out_last  - current element is the final one of the vector
//   Modports:
//     master    - sending side (weight_streamer)
//     slave     - receiving side
interface weight_streamer_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/weight_streamer.sv
// weight_streamer
//   Captures DEPTH weights of WIDTH bits in one cycle and sends them one
//   element per valid/ready handshake, element 0 first. out_last flags the
//   final element; done pulses for one cycle after it is accepted.
//   Ports:
//     CLK     - clock, rising edge
//     reset   - asynchronous, active-high; clears all state
//     load    - capture request, honoured only when idle
//     data_in - DEPTH elements, element i at data_in[i*WIDTH +: WIDTH]
//     os      - stream interface (master): out_valid/out_ready/out_data/out_last
//     busy    - high while streaming a vector
//     done    - one-cycle pulse after the last element is accepted
//   All outputs come straight from registers.
module weight_streamer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] data_in,
    weight_streamer_if.master      os,
    output logic                   busy,
    output logic                   done
);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]       state;
    logic [IDXW-1:0]  idx;
    logic [IDXW-1:0]  idx_nxt;
    logic [WIDTH-1:0] bank [DEPTH];
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             last_r;
    logic             done_r;

    assign idx_nxt      = idx + 1'b1;
    assign os.out_valid = valid_r;
    assign os.out_data  = data_r;
    assign os.out_last  = last_r;
    assign busy         = (state == STREAM);
    assign done         = done_r;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            valid_r <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            bank[i] <= data_in[i*WIDTH +: WIDTH];
                        end
                        idx     <= '0;
                        state   <= STREAM;
                        valid_r <= 1'b1;
                        // Element 0 comes from data_in directly: the bank
                        // is being written on this same edge.
                        data_r  <= data_in[WIDTH-1:0];
                        last_r  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (valid_r && os.out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx    <= idx_nxt;
                            data_r <= bank[idx_nxt];
                            last_r <= (idx_nxt == LAST_IDX);
                        end else begin
                            idx     <= '0;
                            state   <= IDLE;
                            valid_r <= 1'b0;
                            data_r  <= '0;
                            last_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/weight_streamer.md
# weight_streamer

Parallel-load, serial-out streamer that feeds the neuron datapath's 8-bit operand registers. It captures a vector of `DEPTH` weights in one cycle and presents them one element per handshake, lowest element first, over a valid/ready interface. `out_last` marks the final element, and a one-cycle `done` pulse follows it. The block is the sending end of the interface whose receiving end is a plain clocked register capturing `D` into `Q`.

## Interface
- `WIDTH`, 8: bits per element.
- `DEPTH`, 4: elements per vector; must be ≥ 2.
- `CLK` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `load` input 1: capture request; honoured only in IDLE.
- `data_in` input `DEPTH*WIDTH`: element i = `data_in[i*WIDTH +: WIDTH]`; element 0 is sent first.
- `out_ready` input 1: consumer accepts `out_data` on this edge.
- `out_valid` output 1: `out_data` holds a valid element.
- `out_data` output `WIDTH`: current element; 0 whenever `out_valid`=0.
- `out_last` output 1: current element is element `DEPTH-1`; only ever high with `out_valid`.
- `busy` output 1: high in STREAM.
- `done` output 1: one-cycle pulse after the last element is accepted.

## Operation
- States: IDLE, STREAM.
- Reset state: IDLE, index=0, shadow bank=0, and all outputs 0 (`out_valid`, `out_data`, `out_last`, `busy`, `done`).
- IDLE with `load`=1 at an edge:
  - copy the whole of `data_in` into the shadow bank;
  - set index=0 and go to STREAM;
  - `out_valid`=1, `out_data`=element 0, `busy`=1.
- IDLE with `load`=0: stay in IDLE; outputs stay at reset values, except that `done` may be high for one cycle on IDLE entry.
- STREAM, handshake = `out_valid & out_ready` at an edge:
  - If index < `DEPTH-1`: index+1; `out_data` becomes the next element; `out_last`=1 when the new index is `DEPTH-1`.
  - If index = `DEPTH-1`: go to IDLE; `out_valid`, `out_last`, `busy` and `out_data` clear; `done`=1 for exactly one cycle.
- STREAM without a handshake: all outputs hold (no change to data, valid or last).
- `load` in STREAM is ignored. The shadow bank does not change, so `data_in` may change freely after capture.
- Index width is `$clog2(DEPTH)`. The index never wraps; the last handshake returns to IDLE instead.
- All outputs are registered. There is no combinational path from `out_ready` or `load` to any output.

## Timing
- Load latency: `load` sampled at edge k gives `out_valid`=1 with element 0 in the cycle after edge k.
- Throughput: with `out_ready` held high, one element per cycle. A vector takes `DEPTH` cycles from the first valid cycle to the last accepted edge.
- `done` is high for the cycle after the final handshake edge. The block is already in IDLE then, so a `load` in that cycle is accepted. Back-to-back vectors have a gap of one cycle with `out_valid`=0.
- Stall: `out_ready`=0 for any number of cycles holds the current element unchanged.
- Reset mid-stream: `out_valid`, `busy`, `out_last` and `done` fall asynchronously without waiting for an edge. The partial vector is discarded. The first edge after reset release with `load`=1 starts a fresh vector.
- `load` and reset deasserting in the same cycle: `load` is honoured at the first edge where reset is low.

## Test plan
- Reset then idle: `reset`=1, then 0 with `load`=0 for 5 cycles. Required: all outputs 0 and `busy`=0 throughout.
- Full stream: `DEPTH`=4, `data_in`={4,2,10,1}, `load` pulse, `out_ready`=1. Required:
  - `out_data` = 1, 10, 2, 4 on four consecutive cycles;
  - `out_last` high only with 4;
  - `done` high for one cycle next, with `out_valid`=0.
- Backpressure: same vector, `out_ready`=0 for 3 cycles while element 10 is shown. Required: `out_data`=10 and `out_valid`=1 held for all 3 cycles; streaming resumes with 2 after `out_ready` rises.
- Load ignored while busy: assert `load` with `data_in`={9,9,9,9} during STREAM. Required: the original 1, 10, 2, 4 stream completes unchanged.
- Back-to-back: assert `load` with {8,7,6,5} in the `done` cycle. Required: the next cycle shows `out_valid`=1 with `out_data`=5.
- Async reset mid-stream: raise `reset` between edges while element 10 is shown. Required: `out_valid`=0, `busy`=0 and `out_data`=0 immediately; a later `load` restarts from element 0.
